// File: rtl/xadac_vrf_issue.sv
// Vector register file issue stage: scoreboard hazard check, VRF read/write routing,
// and a one-entry operand register toward the execute unit with writeback forwarding.
module xadac_vrf_issue #(
  parameter  int NoVec = 32,
  parameter  int NoVs  = 2,
  parameter  int VecW  = 128,
  localparam int AW    = $clog2(NoVec)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NoVs-1:0][AW-1:0]       req_vs,
  input  logic [AW-1:0]                 req_vd,
  input  logic                          req_wr,
  output logic                          ex_valid,
  input  logic                          ex_ready,
  output logic [NoVs-1:0][VecW-1:0]     ex_vs_data,
  output logic [AW-1:0]                 ex_vd,
  output logic                          ex_wr,
  input  logic                          wb_valid,
  input  logic [AW-1:0]                 wb_vd,
  input  logic [VecW-1:0]               wb_data,
  output logic [NoVs-1:0][AW-1:0]       vrf_raddr,
  input  logic [NoVs-1:0][VecW-1:0]     vrf_rdata,
  output logic [AW-1:0]                 vrf_waddr,
  output logic [VecW-1:0]               vrf_wdata,
  output logic                          vrf_we,
  output logic                          idle
);

  logic [NoVec-1:0]            busy_reg, busy_next, busy_eff, wb_mask;
  logic [NoVs-1:0]             raw_hit;
  logic                        waw_hit, hazard, fire;
  logic [NoVs-1:0][VecW-1:0]   operand;
  logic                        ex_valid_reg, ex_valid_next;
  logic [NoVs-1:0][VecW-1:0]   ex_data_reg;
  logic [AW-1:0]               ex_vd_reg;
  logic                        ex_wr_reg;

  // A writeback this cycle already frees its register for the hazard check.
  for (genvar gi = 0; gi < NoVec; gi++) begin : g_wbmask
    assign wb_mask[gi] = wb_valid && (wb_vd == AW'(gi));
  end
  assign busy_eff = busy_reg & ~wb_mask;

  // VRF write lands at the next edge, so same-cycle writeback data must bypass the array.
  for (genvar gi = 0; gi < NoVs; gi++) begin : g_src
    assign vrf_raddr[gi] = req_vs[gi];
    assign raw_hit[gi]   = busy_eff[req_vs[gi]];
    assign operand[gi]   = (wb_valid && (wb_vd == req_vs[gi])) ? wb_data : vrf_rdata[gi];
  end

  assign waw_hit   = req_wr && busy_eff[req_vd];
  assign hazard    = (|raw_hit) || waw_hit;
  assign req_ready = !hazard && (!ex_valid_reg || ex_ready);
  assign fire      = req_valid && req_ready;

  always_comb begin
    busy_next = busy_eff;
    if (fire && req_wr) begin
      busy_next[req_vd] = 1'b1;
    end
    ex_valid_next = ex_valid_reg;
    if (fire) begin
      ex_valid_next = 1'b1;
    end else if (ex_ready) begin
      ex_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg     <= '0;
      ex_valid_reg <= 1'b0;
      ex_data_reg  <= '0;
      ex_vd_reg    <= '0;
      ex_wr_reg    <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      ex_valid_reg <= ex_valid_next;
      if (fire) begin
        ex_data_reg <= operand;
        ex_vd_reg   <= req_vd;
        ex_wr_reg   <= req_wr;
      end
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_vs_data = ex_data_reg;
  assign ex_vd      = ex_vd_reg;
  assign ex_wr      = ex_wr_reg;
  assign vrf_waddr  = wb_vd;
  assign vrf_wdata  = wb_data;
  assign vrf_we     = wb_valid;
  assign idle       = (busy_reg == '0) && !ex_valid_reg;

endmodule

// File: tb/tb_xadac_vrf_issue.sv
// Bench for xadac_vrf_issue: directed vector table, hand-written reset sequence,
// and randomized traffic checked against a scoreboard/VRF reference model.
module tb_xadac_vrf_issue;
  localparam int NV = 32;
  localparam int NS = 2;
  localparam int W  = 128;
  localparam int AW = 5;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  req_valid, req_ready, req_wr;
  logic [NS-1:0][AW-1:0] req_vs;
  logic [AW-1:0]         req_vd;
  logic                  ex_valid, ex_ready, ex_wr;
  logic [NS-1:0][W-1:0]  ex_vs_data;
  logic [AW-1:0]         ex_vd;
  logic                  wb_valid;
  logic [AW-1:0]         wb_vd;
  logic [W-1:0]          wb_data;
  logic [NS-1:0][AW-1:0] vrf_raddr;
  logic [NS-1:0][W-1:0]  vrf_rdata;
  logic [AW-1:0]         vrf_waddr;
  logic [W-1:0]          vrf_wdata;
  logic                  vrf_we, idle;

  always #5 clk = ~clk;

  xadac_vrf_issue dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_vs(req_vs), .req_vd(req_vd), .req_wr(req_wr),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_vs_data(ex_vs_data), .ex_vd(ex_vd), .ex_wr(ex_wr),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .wb_data(wb_data),
    .vrf_raddr(vrf_raddr), .vrf_rdata(vrf_rdata), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata),
    .vrf_we(vrf_we), .idle(idle)
  );

  // Behavioural VRF array seen by the DUT read ports
  logic [W-1:0] vrf_mem [NV];
  always_comb begin
    for (int i = 0; i < NS; i++) vrf_rdata[i] = vrf_mem[vrf_raddr[i]];
  end

  // Reference model state
  logic [NV-1:0]        m_busy;
  logic                 m_exv, m_wr;
  logic [AW-1:0]        m_vd;
  logic [NS-1:0][W-1:0] m_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic        rv;
    logic [4:0]  vs0, vs1, vd;
    logic        wr, exr, wbv;
    logic [4:0]  wbvd;
    logic [31:0] wbd;
    logic        rdy, exv, idl, ckd;
    logic [31:0] d0;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [W-1:0] rep(input logic [31:0] p);
    return {4{p}};
  endfunction

  function automatic vec_t mk(input logic rv, input int vs0, input int vs1, input int vd,
                              input logic wr, input logic exr, input logic wbv, input int wbvd,
                              input logic [31:0] wbd, input logic rdy, input logic exv,
                              input logic idl, input logic ckd, input logic [31:0] d0);
    vec_t v;
    v.rv = rv; v.vs0 = AW'(vs0); v.vs1 = AW'(vs1); v.vd = AW'(vd);
    v.wr = wr; v.exr = exr; v.wbv = wbv; v.wbvd = AW'(wbvd); v.wbd = wbd;
    v.rdy = rdy; v.exv = exv; v.idl = idl; v.ckd = ckd; v.d0 = d0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Ready as the rules define it: no source or destination still owned by an in-flight writer
  // (a writeback this cycle releases its register), and room in the operand register.
  function automatic logic model_ready();
    logic [NV-1:0] live;
    logic hz;
    live = m_busy;
    if (wb_valid) live[wb_vd] = 1'b0;
    hz = 1'b0;
    for (int i = 0; i < NS; i++) if (live[req_vs[i]]) hz = 1'b1;
    if (req_wr && live[req_vd]) hz = 1'b1;
    return !hz && (!m_exv || ex_ready);
  endfunction

  task automatic step();
    logic exp_rdy, f;
    logic [NS-1:0][W-1:0] ops;
    @(negedge clk);
    exp_rdy = model_ready();
    chk("req_ready", 256'(req_ready), 256'(exp_rdy));
    chk("ex_valid", 256'(ex_valid), 256'(m_exv));
    if (m_exv) begin
      chk("ex_vs_data", 256'(ex_vs_data), 256'(m_data));
      chk("ex_vd", 256'(ex_vd), 256'(m_vd));
      chk("ex_wr", 256'(ex_wr), 256'(m_wr));
    end
    chk("idle", 256'(idle), 256'((m_busy == '0) && !m_exv));
    chk("vrf_raddr", 256'(vrf_raddr), 256'(req_vs));
    chk("vrf_we", 256'(vrf_we), 256'(wb_valid));
    if (wb_valid) begin
      chk("vrf_waddr", 256'(vrf_waddr), 256'(wb_vd));
      chk("vrf_wdata", 256'(vrf_wdata), 256'(wb_data));
    end
    f = req_valid && exp_rdy;
    for (int i = 0; i < NS; i++)
      ops[i] = (wb_valid && wb_vd == req_vs[i]) ? wb_data : vrf_mem[req_vs[i]];
    $display("cyc %0d req=%0b vs=%0d,%0d vd=%0d wr=%0b rdy=%0b fire=%0b exv=%0b exr=%0b wb=%0b/%0d",
             cyc, req_valid, req_vs[0], req_vs[1], req_vd, req_wr, req_ready, f, ex_valid,
             ex_ready, wb_valid, wb_vd);
    @(posedge clk);
    #1;
    if (wb_valid) begin
      m_busy[wb_vd]  = 1'b0;
      vrf_mem[wb_vd] = wb_data;
    end
    if (f) begin
      m_exv  = 1'b1;
      m_data = ops;
      m_vd   = req_vd;
      m_wr   = req_wr;
      if (req_wr) m_busy[req_vd] = 1'b1;
    end else if (m_exv && ex_ready) begin
      m_exv = 1'b0;
    end
    cyc++;
  endtask

  task automatic model_reset();
    m_busy = '0; m_exv = 1'b0; m_wr = 1'b0; m_vd = '0; m_data = '0;
  endtask

  initial begin
    for (int r = 0; r < NV; r++) vrf_mem[r] = rep(32'h1000_0000 + r);
    model_reset();
    req_valid = 1'b0; req_vs = '0; req_vd = '0; req_wr = 1'b0; ex_ready = 1'b0;
    wb_valid = 1'b1; wb_vd = AW'(5); wb_data = rep(32'hCAFE_0005);

    // Reset state and pass-through while held in reset
    #12;
    chk("rst_ex_valid", 256'(ex_valid), 256'(0));
    chk("rst_idle", 256'(idle), 256'(1));
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_ex_data", 256'(ex_vs_data), 256'(0));
    chk("rst_ex_vd", 256'(ex_vd), 256'(0));
    chk("rst_ex_wr", 256'(ex_wr), 256'(0));
    chk("rst_vrf_waddr", 256'(vrf_waddr), 256'(5));
    chk("rst_vrf_we", 256'(vrf_we), 256'(1));
    wb_valid = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    //           rv  vs0 vs1 vd wr exr wbv wbvd wbd            rdy exv idl ckd d0
    tbl[0]  = mk(1,  2,  3,  1, 1, 1,  0,  0,   32'h0,         1,  0,  1,  0,  32'h0);
    tbl[1]  = mk(1,  5,  6,  4, 1, 1,  0,  0,   32'h0,         1,  1,  0,  1,  32'h1000_0002);
    tbl[2]  = mk(1,  1,  2,  8, 1, 1,  0,  0,   32'h0,         0,  1,  0,  0,  32'h0);
    tbl[3]  = mk(1,  1,  2,  8, 1, 1,  0,  0,   32'h0,         0,  0,  0,  0,  32'h0);
    tbl[4]  = mk(1,  1,  2,  8, 1, 1,  1,  1,   32'hA5A5_A5A5, 1,  0,  0,  0,  32'h0);
    tbl[5]  = mk(0,  0,  0,  0, 0, 0,  0,  0,   32'h0,         0,  1,  0,  1,  32'hA5A5_A5A5);
    tbl[6]  = mk(1, 10, 11, 12, 1, 0,  0,  0,   32'h0,         0,  1,  0,  1,  32'hA5A5_A5A5);
    tbl[7]  = mk(1, 10, 11, 12, 1, 0,  0,  0,   32'h0,         0,  1,  0,  1,  32'hA5A5_A5A5);
    tbl[8]  = mk(1, 10, 11, 12, 1, 0,  0,  0,   32'h0,         0,  1,  0,  1,  32'hA5A5_A5A5);
    tbl[9]  = mk(1, 10, 11, 12, 1, 1,  0,  0,   32'h0,         1,  1,  0,  1,  32'hA5A5_A5A5);
    tbl[10] = mk(1,  0,  0,  4, 1, 1,  1,  4,   32'h0404_0404, 1,  1,  0,  1,  32'h1000_000A);
    tbl[11] = mk(1,  4,  0,  0, 0, 1,  0,  0,   32'h0,         0,  1,  0,  0,  32'h0);
    tbl[12] = mk(0,  0,  0,  0, 0, 1,  1,  9,   32'h0000_1234, 1,  0,  0,  0,  32'h0);
    tbl[13] = mk(0,  0,  0,  0, 0, 1,  1,  8,   32'h0808_0808, 1,  0,  0,  0,  32'h0);
    tbl[14] = mk(0,  0,  0,  0, 0, 1,  1, 12,   32'h0C0C_0C0C, 1,  0,  0,  0,  32'h0);
    tbl[15] = mk(0,  0,  0,  0, 0, 1,  1,  4,   32'h0404_0405, 1,  0,  0,  0,  32'h0);
    tbl[16] = mk(0,  0,  0,  0, 0, 1,  0,  0,   32'h0,         1,  0,  1,  0,  32'h0);

    foreach (tbl[k]) begin
      req_valid = tbl[k].rv; req_vs[0] = tbl[k].vs0; req_vs[1] = tbl[k].vs1;
      req_vd = tbl[k].vd; req_wr = tbl[k].wr; ex_ready = tbl[k].exr;
      wb_valid = tbl[k].wbv; wb_vd = tbl[k].wbvd; wb_data = rep(tbl[k].wbd);
      #2;
      chk("tbl_req_ready", 256'(req_ready), 256'(tbl[k].rdy));
      chk("tbl_ex_valid", 256'(ex_valid), 256'(tbl[k].exv));
      chk("tbl_idle", 256'(idle), 256'(tbl[k].idl));
      if (tbl[k].ckd) chk("tbl_ex_vs_data0", 256'(ex_vs_data[0]), 256'(rep(tbl[k].d0)));
      step();
    end

    // Asynchronous reset while v3 is busy and the operand register is full
    req_valid = 1'b1; req_vs = '0; req_vd = AW'(3); req_wr = 1'b1; ex_ready = 1'b0;
    wb_valid = 1'b0;
    step();
    req_vs[0] = AW'(3); req_vs[1] = AW'(3); req_vd = '0; req_wr = 1'b0;
    #1;
    chk("pre_rst_ex_valid", 256'(ex_valid), 256'(1));
    chk("pre_rst_req_ready", 256'(req_ready), 256'(0));
    rstn = 1'b0;
    #1;
    chk("arst_ex_valid", 256'(ex_valid), 256'(0));
    chk("arst_idle", 256'(idle), 256'(1));
    chk("arst_req_ready", 256'(req_ready), 256'(1));
    chk("arst_ex_vd", 256'(ex_vd), 256'(0));
    chk("arst_ex_data", 256'(ex_vs_data), 256'(0));
    rstn = 1'b1;
    model_reset();
    ex_ready = 1'b1;
    step();

    // Randomized traffic; writebacks mostly target registers the model knows are busy
    for (int n = 0; n < 400; n++) begin
      req_valid = ($urandom_range(3, 0) != 0);
      req_vs[0] = AW'($urandom_range(7, 0));
      req_vs[1] = AW'($urandom_range(7, 0));
      req_vd    = AW'($urandom_range(7, 0));
      req_wr    = 1'($urandom_range(1, 0));
      ex_ready  = ($urandom_range(3, 0) != 0);
      wb_valid  = ($urandom_range(2, 0) == 0);
      wb_vd     = AW'($urandom_range(NV - 1, 0));
      if (m_busy != '0 && $urandom_range(3, 0) != 0) begin
        int s;
        s = $urandom_range(NV - 1, 0);
        for (int j = 0; j < NV; j++) begin
          if (m_busy[(s + j) % NV]) begin
            wb_vd = AW'((s + j) % NV);
            break;
          end
        end
      end
      wb_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/xadac_vrf_issue.md
# xadac_vrf_issue

Issue stage directly upstream of the vector register file physical array. Accepts decoded vector operations, resolves register hazards with a per-register scoreboard, and drives the VRF read ports. Captures operands (with writeback forwarding) into a one-entry pipeline register for the execute unit, and routes execute writebacks into the VRF write port.

## Interface
- NoVec, 32, number of vector registers; VecAddrT width is $clog2(NoVec)
- NoVs, 2, source operands per operation, equal to the VRF read port count
- VecW, 128, vector register width in bits (VecDataT)
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  reset, asynchronous and active-low
- req_valid  in  1  operation offered
- req_ready  out  1  operation accepted this cycle when req_valid is also high
- req_vs  in  NoVs×VecAddrT  source register indices
- req_vd  in  VecAddrT  destination register index
- req_wr  in  1  operation writes req_vd
- ex_valid  out  1  operand register holds an operation
- ex_ready  in  1  execute unit consumes the operation
- ex_vs_data  out  NoVs×VecW  captured source operands
- ex_vd  out  VecAddrT  destination index
- ex_wr  out  1  destination write flag
- wb_valid  in  1  writeback strobe; always accepted, no ready
- wb_vd  in  VecAddrT  writeback destination
- wb_data  in  VecW  writeback data
- vrf_raddr  out  NoVs×VecAddrT  to VRF read ports; equals req_vs combinationally
- vrf_rdata  in  NoVs×VecW  combinational VRF read data
- vrf_waddr  out  VecAddrT  equals wb_vd
- vrf_wdata  out  VecW  equals wb_data
- vrf_we  out  1  equals wb_valid
- idle  out  1  no scoreboard bit set and ex_valid low

## Operation
- Scoreboard: busy[NoVec] register. Effective view busy_eff = busy with bit wb_vd cleared when wb_valid is high.
- Hazard: hazard = any busy_eff[req_vs[i]] (RAW) or (req_wr and busy_eff[req_vd]) (WAW).
- req_ready = !hazard and (!ex_valid or ex_ready). Combinational; depends on req_valid only through the fire condition below.
- fire = req_valid and req_ready.
- Forwarding: for each i, operand_i = wb_data when wb_valid and wb_vd == req_vs[i]; otherwise operand_i = vrf_rdata[i]. The VRF write lands at the next edge, so forwarding is mandatory.
- On fire: ex_vs_data <= operands, ex_vd <= req_vd, ex_wr <= req_wr, ex_valid <= 1. If req_wr is high, busy[req_vd] <= 1.
- If ex_valid and ex_ready and no fire: ex_valid <= 0. Payload registers hold.
- Writeback: busy[wb_vd] <= 0 unless the same cycle sets it through fire.
  - Set has priority over clear. This case is only reachable when the WAW check passed via busy_eff.
- Writeback to a non-busy register: the VRF is still written, and busy is unchanged.
- Registers with busy set but no pending writeback stall forever. Flushing is the upstream's responsibility.

## Timing
- Reset (asynchronous, rstn low):
  - busy = 0, ex_valid = 0, ex_vs_data = 0, ex_vd = 0, ex_wr = 0.
  - idle = 1, req_ready = 1.
  - Pass-through VRF outputs follow their inputs.
- Reset asserted mid-operation discards the held operation and clears all busy bits immediately. No writeback is replayed.
- Issue latency: fire in cycle N gives ex_valid high from cycle N+1.
- Throughput: one operation per cycle when ex_ready is held high and there are no hazards.
- ex_valid stays high and the ex_* payload stays stable until ex_ready is sampled high. There is no combinational path from ex_ready to ex_* outputs.
- Writeback in cycle N:
  - VRF is updated at edge N→N+1 and busy is cleared at the same edge.
  - A dependent request waiting in cycle N fires in cycle N itself with forwarded data.
- All outputs are registered except req_ready, vrf_raddr, vrf_waddr, vrf_wdata and vrf_we.

## Test plan
- Reset then independent ops: v1=v2+v3 (wr v1), then v4=v5+v6 on consecutive cycles with ex_ready=1 -> both fire back-to-back; ex_valid high at N+1 and N+2; busy[1] and busy[4] set.
- RAW stall: op writes v1; next op reads v1 -> req_ready=0 until wb_valid with wb_vd=1, wb_data=0xA5..A5. In that writeback cycle the op fires and ex_vs_data[0]=0xA5..A5 (forwarded, not the stale VRF value).
- WAW with same-cycle writeback: busy[7] set; wb to v7 coincides with a new op writing v7 -> op fires; busy[7] remains 1 after the edge.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> req_ready=0 and ex_* payload stable. On release, the next op fires in the same cycle ex_ready rises.
- Async reset mid-flight: busy[3] set and ex_valid=1, then pulse rstn low between edges -> outputs clear immediately; idle=1; a read of v3 is accepted on the first cycle after release.
- Stray writeback to non-busy v9 with 0x1234 -> vrf_we=1, vrf_waddr=9, busy unchanged, idle unchanged.
